dual_issue_buffer: RTL and testbench
====================================

Name: dual_issue_buffer

Overview:
- Instruction buffer between fetch_top and decode_top in the dual-issue core.
- Accepts an instruction pair per cycle from fetch and stores single-instruction entries in a circular buffer.
- Each cycle it presents 0, 1 or 2 instructions to decode. Dual issue is suppressed on a RAW dependency or when slot A is control flow.
- A flush (taken branch/jump) empties the buffer.

Parameters:
- DATA_WIDTH, 32, instruction/PC width
- DEPTH, 8, entries (single instructions); power of two, >= 4

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- flush  in  1  discard all entries (driven from PCSrc)
- in_valid  in  1  fetch pair valid
- InstrA_in  in  DATA_WIDTH  older fetched instruction
- InstrB_in  in  DATA_WIDTH  younger fetched instruction (PC_in+4)
- PC_in  in  DATA_WIDTH  PC of InstrA_in
- in_ready  out  1  buffer has >= 2 free entries
- dec_ready  in  1  decode accepts presented instructions this cycle
- InstrA  out  DATA_WIDTH  slot A instruction
- InstrB  out  DATA_WIDTH  slot B instruction
- PCA  out  DATA_WIDTH  slot A PC
- PCB  out  DATA_WIDTH  slot B PC
- validA  out  1  slot A valid
- validB  out  1  slot B valid
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Storage: DEPTH x {instr, pc}. Head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count register saturates at neither end because the handshakes prevent it.
- Reset (rst=0, asynchronous): head=tail=count=0. Outputs: validA=validB=0, in_ready=1, InstrA=InstrB=32'h00000013 (NOP), PCA=PCB=0.
- Push: when in_valid && in_ready && !flush, write InstrA_in/PC_in at tail and InstrB_in/PC_in+4 at tail+1, then tail+=2.
- in_ready = (DEPTH-count) >= 2. It is combinational from registered count.
- Presentation: combinational from the head and head+1 entries. Latency from push to visibility is 1 cycle; there is no bypass of an empty buffer.
- validA = count>=1.
- validB = count>=2 && !hazard && !ctrlA.
- Invalid slots drive the NOP instruction with PC 0.
- rdA = InstrA[11:7].
- A writes rd when opcode is one of 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, and rdA != 0.
- B reads rs1 (InstrB[19:15]) unless opcode is 0110111, 0010111 or 1101111.
- B reads rs2 (InstrB[24:20]) when opcode is 0110011, 0100011 or 1100011.
- hazard = A writes rd && ((B reads rs1 && rs1B==rdA) || (B reads rs2 && rs2B==rdA)).
- ctrlA = opcode of A is 1100011, 1101111 or 1100111. The younger slot waits until branch resolution.
- Pop: when dec_ready, head += validA+validB.
- Count update: count_next = count + 2*push - pop.
- Simultaneous push and pop are legal; count updates by the net amount.
- Flush: synchronous. Next cycle head=tail=count=0. Flush overrides any same-cycle push and pop, and the pushed pair is dropped.
- Full (count = DEPTH or DEPTH-1): in_ready=0. Fetch must hold its pair.
- Empty: both valids 0. dec_ready is ignored.
- Wrap-around: a pair may straddle index DEPTH-1/0, and reads at head+1 wrap the same way.
- Reset mid-operation: all entries are discarded immediately. Stale storage contents are never presented, because the valids derive only from count.

Optional Feature:
- Macro: DUAL_ISSUE_BUFFER_STATS_EN
- With the macro: adds output ports single_issue_cnt (32 bits) and hazard_cnt (32 bits), both reset to 0 by rst and not cleared by flush.
  - single_issue_cnt increments each cycle dec_ready && validA && !validB && count>=2.
  - hazard_cnt increments each such cycle where hazard=1.
  - Both counters wrap at 2^32.
- Without the macro: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> count=0, validA=validB=0, InstrA=0x00000013, in_ready=1. After release, the first push is visible the next cycle.
- Independent pair: push addi x1,x0,5 (0x00500093) / addi x2,x0,7 (0x00700113), PC_in=0x0, dec_ready=1 -> next cycle validA=validB=1, PCA=0x0, PCB=0x4. The following cycle count=0.
- RAW hazard: push 0x00500093 / add x3,x1,x1 (0x001081B3) -> cycle 1: validA=1, validB=0. Cycle 2: add is in slot A with PCA=0x4.
- Control in A: push beq x0,x0,8 (0x00000463) / addi -> only beq issues. Assert flush the next cycle together with a new push -> count=0 the cycle after and the new pair is dropped.
- Full/wrap: dec_ready=0 and push 4 pairs with DEPTH=8 -> in_ready=0 at count=8. Then set dec_ready=1 while pushing continuously with independent instructions for 10 cycles -> in-order PCs with no loss or duplication across the index 7/0 boundary.
- Stats (DUAL_ISSUE_BUFFER_STATS_EN defined): run the RAW hazard scenario 3 times -> hazard_cnt=3, single_issue_cnt=3. A flush leaves both counters unchanged.

Source files
------------

// File: rtl/dual_issue_buffer.sv
// Instruction buffer between fetch and decode: accepts a fetch pair per cycle, issues 0/1/2 to decode.
// Optional issue statistics counters are enabled with DUAL_ISSUE_BUFFER_STATS_EN.
module dual_issue_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   InstrA_in,
  input  logic [DATA_WIDTH-1:0]   InstrB_in,
  input  logic [DATA_WIDTH-1:0]   PC_in,
  output logic                    in_ready,
  input  logic                    dec_ready,
  output logic [DATA_WIDTH-1:0]   InstrA,
  output logic [DATA_WIDTH-1:0]   InstrB,
  output logic [DATA_WIDTH-1:0]   PCA,
  output logic [DATA_WIDTH-1:0]   PCB,
  output logic                    validA,
  output logic                    validB,
  output logic [$clog2(DEPTH):0]  count
`ifdef DUAL_ISSUE_BUFFER_STATS_EN
  ,
  output logic [31:0]             single_issue_cnt,
  output logic [31:0]             hazard_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_pc    [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_nx;
  logic [AW-1:0] tail_nx;
  logic [CW-1:0] cnt_q;

  logic [DATA_WIDTH-1:0] raw_a;
  logic [DATA_WIDTH-1:0] raw_b;
  logic [6:0]            a_op;
  logic [6:0]            b_op;
  logic                  a_writes_rd;
  logic                  b_reads_rs1;
  logic                  b_reads_rs2;
  logic                  hazard;
  logic                  ctrl_a;
  logic                  has_two;
  logic                  push;
  logic [1:0]            pop_cnt;

  assign head_nx = head + 1'b1;
  assign tail_nx = tail + 1'b1;

  assign count    = cnt_q;
  assign in_ready = cnt_q <= CW'(DEPTH - 2);
  assign push     = in_valid && in_ready && !flush;

  assign raw_a = mem_instr[head];
  assign raw_b = mem_instr[head_nx];
  assign a_op  = raw_a[6:0];
  assign b_op  = raw_b[6:0];

  assign a_writes_rd = (a_op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                     7'b0010111, 7'b1101111, 7'b1100111})
                       && (raw_a[11:7] != 5'd0);
  assign b_reads_rs1 = !(b_op inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign b_reads_rs2 = b_op inside {7'b0110011, 7'b0100011, 7'b1100011};

  assign hazard = a_writes_rd &&
                  ((b_reads_rs1 && (raw_b[19:15] == raw_a[11:7])) ||
                   (b_reads_rs2 && (raw_b[24:20] == raw_a[11:7])));

  // Younger slot holds back until the control-flow instruction in A resolves.
  assign ctrl_a = a_op inside {7'b1100011, 7'b1101111, 7'b1100111};

  // Valids come only from count, so stale storage is never presented.
  assign has_two = cnt_q >= CW'(2);
  assign validA  = cnt_q != '0;
  assign validB  = has_two && !hazard && !ctrl_a;

  assign InstrA = validA ? raw_a          : NOP;
  assign PCA    = validA ? mem_pc[head]   : '0;
  assign InstrB = validB ? raw_b          : NOP;
  assign PCB    = validB ? mem_pc[head_nx] : '0;

  assign pop_cnt = !dec_ready ? 2'd0 : (validB ? 2'd2 : (validA ? 2'd1 : 2'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
    end else begin
      head  <= head + AW'(pop_cnt);
      if (push) begin
        tail <= tail + AW'(2);
      end
      cnt_q <= cnt_q + (push ? CW'(2) : CW'(0)) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail]    <= InstrA_in;
      mem_pc[tail]       <= PC_in;
      mem_instr[tail_nx] <= InstrB_in;
      mem_pc[tail_nx]    <= PC_in + DATA_WIDTH'(4);
    end
  end

`ifdef DUAL_ISSUE_BUFFER_STATS_EN
  // Counts cycles where a second instruction was available but held back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      single_issue_cnt <= '0;
      hazard_cnt       <= '0;
    end else if (dec_ready && validA && !validB && has_two) begin
      single_issue_cnt <= single_issue_cnt + 32'd1;
      if (hazard) begin
        hazard_cnt <= hazard_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dual_issue_buffer.sv
// Self-checking bench for dual_issue_buffer: directed scenarios plus random traffic against a queue model.
module tb_dual_issue_buffer;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI1  = 32'h0050_0093;
  localparam logic [31:0] ADDI2  = 32'h0070_0113;
  localparam logic [31:0] ADD311 = 32'h0010_81B3;
  localparam logic [31:0] BEQ    = 32'h0000_0463;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        dec_ready = 1'b0;
  logic [31:0] InstrA_in = '0;
  logic [31:0] InstrB_in = '0;
  logic [31:0] PC_in = '0;
  logic        in_ready;
  logic [31:0] InstrA, InstrB, PCA, PCB;
  logic        validA, validB;
  logic [3:0]  count;
`ifdef DUAL_ISSUE_BUFFER_STATS_EN
  logic [31:0] single_issue_cnt, hazard_cnt;
`endif

  int vectors = 0;
  int errors  = 0;

  dual_issue_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .InstrA_in(InstrA_in), .InstrB_in(InstrB_in), .PC_in(PC_in),
    .in_ready(in_ready), .dec_ready(dec_ready),
    .InstrA(InstrA), .InstrB(InstrB), .PCA(PCA), .PCB(PCB),
    .validA(validA), .validB(validB), .count(count)
`ifdef DUAL_ISSUE_BUFFER_STATS_EN
    , .single_issue_cnt(single_issue_cnt), .hazard_cnt(hazard_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_buf;
    flush = 1'b1; in_valid = 1'b0; dec_ready = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    in_valid = 1'b1; InstrA_in = a; InstrB_in = b; PC_in = pc;
  endtask

  // Reference decode rules for the issue model.
  function automatic bit m_writes(input logic [31:0] i);
    bit w;
    case (i[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w && (i[11:7] != 5'd0);
  endfunction

  function automatic bit m_ctrl(input logic [31:0] i);
    return (i[6:0] == 7'b1100011) || (i[6:0] == 7'b1101111) || (i[6:0] == 7'b1100111);
  endfunction

  function automatic bit m_hazard(input logic [31:0] a, input logic [31:0] b);
    bit r1, r2;
    r1 = !((b[6:0] == 7'b0110111) || (b[6:0] == 7'b0010111) || (b[6:0] == 7'b1101111));
    r2 = (b[6:0] == 7'b0110011) || (b[6:0] == 7'b0100011) || (b[6:0] == 7'b1100011);
    return m_writes(a) && ((r1 && b[19:15] == a[11:7]) || (r2 && b[24:20] == a[11:7]));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 9))
      0: op = 7'b0110011; 1: op = 7'b0010011; 2: op = 7'b0000011;
      3: op = 7'b0110111; 4: op = 7'b0010111; 5: op = 7'b1101111;
      6: op = 7'b1100111; 7: op = 7'b0100011; 8: op = 7'b1100011;
      default: op = 7'b0001111;
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  task automatic test_reset;
    #2 rst = 1'b0;
    push_pair(ADDI1, ADDI2, 32'h40);
    dec_ready = 1'b0;
    tick(); tick();
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (validA !== 1'b0 || validB !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b want 00", validA, validB); end
    vectors++; if (InstrA !== NOP || PCA !== 32'h0) begin errors++; $display("FAIL reset_slotA: got %h/%h want %h/0", InstrA, PCA, NOP); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (validA !== 1'b1 || PCA !== 32'h40 || count !== 4'd2) begin
      errors++; $display("FAIL reset_first_push: validA=%b PCA=%h count=%0d want 1/40/2", validA, PCA, count); end
    clear_buf();
  endtask

`ifdef DUAL_ISSUE_BUFFER_STATS_EN
  task automatic test_stats;
    for (int r = 0; r < 3; r++) begin
      push_pair(ADDI1, ADD311, 32'h0);
      dec_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
    end
    vectors++; if (hazard_cnt !== 32'd3) begin errors++; $display("FAIL stats_hazard: got %0d want 3", hazard_cnt); end
    vectors++; if (single_issue_cnt !== 32'd3) begin errors++; $display("FAIL stats_single: got %0d want 3", single_issue_cnt); end
    push_pair(ADDI1, ADD311, 32'h0);
    dec_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    clear_buf();
    vectors++; if (hazard_cnt !== 32'd3 || single_issue_cnt !== 32'd3 || count !== 4'd0) begin
      errors++; $display("FAIL stats_flush: hazard=%0d single=%0d count=%0d want 3/3/0", hazard_cnt, single_issue_cnt, count); end
  endtask
`endif

  task automatic test_independent;
    push_pair(ADDI1, ADDI2, 32'h0);
    dec_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (validA !== 1'b1 || validB !== 1'b1) begin errors++; $display("FAIL indep_valid: got %b%b want 11", validA, validB); end
    vectors++; if (PCA !== 32'h0 || PCB !== 32'h4) begin errors++; $display("FAIL indep_pc: got %h/%h want 0/4", PCA, PCB); end
    vectors++; if (InstrA !== ADDI1 || InstrB !== ADDI2) begin errors++; $display("FAIL indep_instr: got %h/%h want %h/%h", InstrA, InstrB, ADDI1, ADDI2); end
    tick();
    vectors++; if (count !== 4'd0 || validA !== 1'b0) begin errors++; $display("FAIL indep_drain: count=%0d validA=%b want 0/0", count, validA); end
  endtask

  task automatic test_raw;
    push_pair(ADDI1, ADD311, 32'h0);
    dec_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++; if (validA !== 1'b1 || validB !== 1'b0 || InstrB !== NOP || PCB !== 32'h0) begin
      errors++; $display("FAIL raw_c1: validA=%b validB=%b InstrB=%h PCB=%h want 1/0/%h/0", validA, validB, InstrB, PCB, NOP); end
    tick();
    vectors++; if (InstrA !== ADD311 || PCA !== 32'h4 || validA !== 1'b1 || validB !== 1'b0 || count !== 4'd1) begin
      errors++; $display("FAIL raw_c2: InstrA=%h PCA=%h v=%b%b count=%0d want %h/4/10/1", InstrA, PCA, validA, validB, count, ADD311); end
    tick();
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL raw_drain: got %0d want 0", count); end
  endtask

  task automatic test_ctrl_flush;
    push_pair(BEQ, ADDI1, 32'h20);
    dec_ready = 1'b1;
    tick();
    vectors++; if (validA !== 1'b1 || validB !== 1'b0 || InstrA !== BEQ || PCA !== 32'h20) begin
      errors++; $display("FAIL ctrl_a: v=%b%b InstrA=%h PCA=%h want 10/%h/20", validA, validB, InstrA, PCA, BEQ); end
    push_pair(ADDI1, ADDI2, 32'h80);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (count !== 4'd0 || validA !== 1'b0 || InstrA !== NOP || PCA !== 32'h0) begin
      errors++; $display("FAIL flush_clear: count=%0d validA=%b InstrA=%h PCA=%h want 0/0/%h/0", count, validA, InstrA, PCA, NOP); end
    tick();
    vectors++; if (count !== 4'd0) begin errors++; $display("FAIL flush_drop: got %0d want 0", count); end
  endtask

  task automatic test_full_wrap;
    int mcount;
    logic [31:0] exp_pc, next_pc;
    bit exp_rdy;
    clear_buf();
    dec_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      push_pair(ADDI1, ADDI2, 32'h100 + 32'(8 * p));
      tick();
    end
    in_valid = 1'b0;
    vectors++; if (count !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("FAIL full: count=%0d in_ready=%b want 8/0", count, in_ready); end
    vectors++; if (validA !== 1'b1 || PCA !== 32'h100) begin errors++; $display("FAIL full_head: validA=%b PCA=%h want 1/100", validA, PCA); end
    mcount = 8; exp_pc = 32'h100; next_pc = 32'h120;
    dec_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      push_pair(ADDI1, ADDI2, next_pc);
      exp_rdy = (DEPTH - mcount) >= 2;
      vectors++; if (in_ready !== exp_rdy || count !== 4'(mcount)) begin
        errors++; $display("FAIL wrap_ready c%0d: in_ready=%b count=%0d want %b/%0d", c, in_ready, count, exp_rdy, mcount); end
      vectors++; if (validA !== 1'b1 || validB !== 1'b1 || PCA !== exp_pc || PCB !== exp_pc + 32'd4) begin
        errors++; $display("FAIL wrap_order c%0d: v=%b%b PCA=%h PCB=%h want 11/%h/%h", c, validA, validB, PCA, PCB, exp_pc, exp_pc + 32'd4); end
      if (exp_rdy) begin mcount += 2; next_pc += 32'd8; end
      mcount -= 2; exp_pc += 32'd8;
      tick();
    end
    in_valid = 1'b0;
    for (int g = 0; g < 20 && mcount > 0; g++) begin
      vectors++; if (validA !== 1'b1 || PCA !== exp_pc) begin
        errors++; $display("FAIL drain_order: validA=%b PCA=%h want 1/%h", validA, PCA, exp_pc); end
      mcount -= 2; exp_pc += 32'd8;
      tick();
    end
    vectors++; if (count !== 4'd0 || exp_pc !== next_pc) begin
      errors++; $display("FAIL wrap_total: count=%0d last_pc=%h want 0/%h", count, exp_pc, next_pc); end
  endtask

  task automatic test_async_reset;
    push_pair(ADDI1, ADDI2, 32'h300);
    dec_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++; if (count !== 4'd0 || validA !== 1'b0 || InstrA !== NOP) begin
      errors++; $display("FAIL async_reset: count=%0d validA=%b InstrA=%h want 0/0/%h", count, validA, InstrA, NOP); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_random;
    logic [31:0] q_i[$];
    logic [31:0] q_p[$];
    clear_buf();
    for (int c = 0; c < 500; c++) begin
      int n;
      bit ea, eb, erdy, do_push;
      logic [31:0] eia, eib, epa, epb;
      in_valid  = $urandom_range(0, 3) != 0;
      dec_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 24) == 0;
      InstrA_in = rand_instr();
      InstrB_in = rand_instr();
      PC_in     = $urandom & 32'hFFFF_FFFC;
      n    = q_i.size();
      ea   = n >= 1;
      eb   = (n >= 2) ? (!m_hazard(q_i[0], q_i[1]) && !m_ctrl(q_i[0])) : 1'b0;
      erdy = (DEPTH - n) >= 2;
      eia  = ea ? q_i[0] : NOP;
      epa  = ea ? q_p[0] : 32'h0;
      eib  = eb ? q_i[1] : NOP;
      epb  = eb ? q_p[1] : 32'h0;
      #1;
      vectors++;
      if ({count, validA, validB, in_ready, InstrA, InstrB, PCA, PCB} !==
          {4'(n), ea, eb, erdy, eia, eib, epa, epb}) begin
        errors++;
        $display("FAIL rand c%0d: got cnt=%0d v=%b%b rdy=%b A=%h/%h B=%h/%h want cnt=%0d v=%b%b rdy=%b A=%h/%h B=%h/%h",
                 c, count, validA, validB, in_ready, InstrA, PCA, InstrB, PCB, n, ea, eb, erdy, eia, epa, eib, epb);
      end
      do_push = in_valid && erdy && !flush;
      if (flush) begin
        q_i.delete(); q_p.delete();
      end else begin
        if (dec_ready && ea) begin void'(q_i.pop_front()); void'(q_p.pop_front()); end
        if (dec_ready && eb) begin void'(q_i.pop_front()); void'(q_p.pop_front()); end
        if (do_push) begin
          q_i.push_back(InstrA_in); q_p.push_back(PC_in);
          q_i.push_back(InstrB_in); q_p.push_back(PC_in + 32'd4);
        end
      end
      @(posedge clk);
      #1;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef DUAL_ISSUE_BUFFER_STATS_EN
    test_stats();
`endif
    test_independent();
    test_raw();
    test_ctrl_flush();
    test_full_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
